// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: one shared nibble decoder, shadow register, tear-free commit.
// Optional blinking is compiled in with `define HEX_BLINK_EN.
module hex_display_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic                    blank_lz,
   input  logic                    blink_en,
   output logic [7*NUM_DIGITS-1:0] seg
);

   localparam int DW    = 4 * NUM_DIGITS;
   localparam int SW    = 7 * NUM_DIGITS;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      COMMIT
   } state_e;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   state_e           state_q, state_d;
   logic [DW-1:0]    data_q, data_d;
   logic             lz_q, lz_d;
   logic             nz_seen_q, nz_seen_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [SW-1:0]    shadow_q, shadow_d;
   logic [SW-1:0]    disp_q, disp_d;

   logic [3:0]       cur_nib;
   logic [6:0]       cur_seg;

   assign load_ready = (state_q == IDLE) && !reset;

   // Digit mux driven by comparing against each constant index keeps the select width-safe.
   always_comb begin
      cur_nib = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) cur_nib = data_q[4*k +: 4];
      end
   end

   // Digit 0 is never blanked so an all-zero value still shows a single "0".
   assign cur_seg = (lz_q && !nz_seen_q && (cur_nib == 4'h0) && (idx_q != '0))
                    ? SEG_BLANK : seg_decode(cur_nib);

   // NOTE: every _d gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      lz_d      = lz_q;
      nz_seen_d = nz_seen_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      disp_d    = disp_q;

      case (state_q)
         IDLE: begin
            if (load_valid && load_ready) begin
               data_d    = load_data;
               lz_d      = blank_lz;
               idx_d     = IDX_TOP;
               nz_seen_d = 1'b0;
               state_d   = CONVERT;
            end
         end
         CONVERT: begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
               if (idx_q == IDX_W'(k)) shadow_d[7*k +: 7] = cur_seg;
            end
            nz_seen_d = nz_seen_q | (cur_nib != 4'h0);
            if (idx_q == '0) state_d = COMMIT;
            else             idx_d   = idx_q - IDX_W'(1);
         end
         COMMIT: begin
            disp_d  = shadow_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the shadow and display registers are reset too, so an aborted conversion can never leak stale digits.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         data_q    <= '0;
         lz_q      <= 1'b0;
         nz_seen_q <= 1'b0;
         idx_q     <= '0;
         shadow_q  <= '1;
         disp_q    <= '1;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         lz_q      <= lz_d;
         nz_seen_q <= nz_seen_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
      end
   end

`ifdef HEX_BLINK_EN
   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             phase_off_q, phase_off_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_off_d = phase_off_q;
      if (!blink_en) begin
         blink_cnt_d = '0;
         phase_off_d = 1'b0;
      end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         phase_off_d = ~phase_off_q;
      end else begin
         blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_q <= '0;
         phase_off_q <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_off_q <= phase_off_d;
      end
   end

   // Blink gating is output-only; conversion and handshake never see the phase.
   assign seg = phase_off_q ? '1 : disp_q;
`else
   localparam int unused_blink_div = BLINK_DIV;
   logic unused_blink_en;
   assign unused_blink_en = blink_en;
   assign seg = disp_q;
`endif

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Multi-digit seven-segment display controller.
- Accepts a packed NUM_DIGITS-wide hex value through a valid/ready handshake.
- Decodes the value one digit per cycle through a single shared nibble decoder into a shadow register, then commits all digits to the outputs at once, so the display never tears.
- Adds optional leading-zero blanking and optional blinking; sits between the datapath and the board HEX outputs.

Parameters:
- NUM_DIGITS, 6, number of hex digits and displays driven (1..8).
- BLINK_DIV, 25000000, clk cycles per blink half-period (≥2); used only with HEX_BLINK_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-high; one clock, synchronous active-high reset.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  controller can accept a load.
- load_data  input  4*NUM_DIGITS  packed digits; digit k = load_data[4k+3:4k], digit 0 rightmost.
- blank_lz  input  1  blank leading zero digits; sampled at the handshake.
- blink_en  input  1  blink the whole display.
- seg  output  7*NUM_DIGITS  active-low segments; display k = seg[7k+6:7k], bit0 = a … bit6 = g.

Behaviour:
- Segment map, 7-bit active-low, hex g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Blank = 7F.
- Reset values:
  - state IDLE.
  - seg all ones (all displays blank).
  - Shadow register all ones; digit index 0; leading-zero flag cleared.
  - Blink counter 0; blink phase = on.
  - load_ready = 0 while reset is high.
- load_ready = (state == IDLE) && !reset; combinational from state.
- States:
  - IDLE:
    - load_ready = 1.
    - On load_valid && load_ready: capture load_data and blank_lz, set idx = NUM_DIGITS-1, clear the "nonzero seen" flag, go to CONVERT.
  - CONVERT:
    - Each cycle, decode captured digit idx into shadow[idx].
    - If blank_lz is captured and no nonzero digit has been seen yet and the digit is 0 and idx != 0, write 7F.
    - Set "nonzero seen" when the digit is nonzero.
    - At idx == 0, go to COMMIT; otherwise decrement idx.
    - Digits are processed MSB first.
  - COMMIT: copy shadow to the display register in one cycle; go to IDLE.
- Timing and handshake:
  - Latency: handshake at cycle T → seg updated and visible at T+NUM_DIGITS+2.
  - The next handshake is possible at T+NUM_DIGITS+2.
  - load_valid while load_ready = 0 is ignored; there is no queuing and the producer must hold valid.
  - load_data is captured at the handshake; later changes to load_data do not affect the conversion in progress.
- Boundary conditions:
  - Digit 0 is never blanked, so value 0 with blank_lz shows a single "0".
  - NUM_DIGITS = 1: CONVERT lasts one cycle.
  - Reset mid-CONVERT or mid-COMMIT aborts; the next cycle is IDLE with seg blank.
  - seg holds its last committed value indefinitely in IDLE.
- Blink (when compiled in):
  - Counter counts 0..BLINK_DIV-1, then wraps to 0 and toggles the phase.
  - Counter runs only while blink_en = 1; when blink_en = 0 the counter and phase reset to 0/on.
  - seg = display register when phase = on, all ones when phase = off.
  - Blink gating is output-only; the handshake and conversion are unaffected.

Optional Feature:
- HEX_BLINK_EN.
- Defined: blink counter and phase logic exist as described above.
- Undefined: no counter is built, blink_en is ignored, BLINK_DIV is unused, and seg = display register at all times.

Test Plan:
- Reset, then NUM_DIGITS=6: seg = all 7F, load_ready = 0 during reset and 1 on the next cycle.
- Load 24'h0123AB with blank_lz = 0 at T → seg (digit5..0) = 40,79,24,30,08,03 at T+8; load_ready low from T+1 to T+7.
- Load 24'h00000F with blank_lz = 1 → digits5..1 = 7F, digit0 = 0E. Load 0 with blank_lz = 1 → only digit0 = 40. Load 24'h000100 → 7F,7F,7F,79,40,40 (internal zeros kept).
- Assert load_valid with new data during CONVERT → ignored, seg unchanged until the first commit; a second load is accepted only after return to IDLE. Change load_data mid-convert → output reflects the captured value.
- Reset asserted in the 3rd CONVERT cycle → seg = all 7F, state IDLE, previous shadow contents never appear.
- HEX_BLINK_EN, BLINK_DIV = 4, blink_en = 1 after loading 24'h888888:
  - seg alternates 00-pattern for 4 cycles and 7F for 4 cycles.
  - Deasserting blink_en → steady 00-pattern next cycle.
  - Without the macro → always steady.
